// File: rtl/prgrm_cnt_stack_if.sv
// Request/status bundle between the decode stage and the program counter / return stack.
// The master drives the requests and the instruction word; the slave (the PC block) drives PC and stack status.
interface prgrm_cnt_stack_if #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 8
);
  logic                       Incrmnt_PC;
  logic                       Ld_Brnch_Addr;
  logic                       Ld_Rtn_Addr;
  logic [31:0]                Crnt_Instrn;
  logic [ADDR_W-1:0]          PC;
  logic [ADDR_W-1:0]          Stack_Top;
  logic [$clog2(DEPTH):0]     Stack_Depth;
  logic                       Stack_Full;
  logic                       Stack_Empty;
  logic                       Stack_Ovfl;
  logic                       Stack_Unfl;

  modport master (
    output Incrmnt_PC, Ld_Brnch_Addr, Ld_Rtn_Addr, Crnt_Instrn,
    input  PC, Stack_Top, Stack_Depth, Stack_Full, Stack_Empty, Stack_Ovfl, Stack_Unfl
  );

  modport slave (
    input  Incrmnt_PC, Ld_Brnch_Addr, Ld_Rtn_Addr, Crnt_Instrn,
    output PC, Stack_Top, Stack_Depth, Stack_Full, Stack_Empty, Stack_Ovfl, Stack_Unfl
  );
endinterface

// File: rtl/prgrm_cnt_stack.sv
// Program counter with a return-address stack: increment, branch, call (push PC+1) and return (pop).
// Priority is return > branch > increment > hold; overflow and underflow are sticky until reset.
module prgrm_cnt_stack #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  prgrm_cnt_stack_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] pc_r;
  logic [PTR_W-1:0]  sp_r;
  logic [ADDR_W-1:0] stack_r [DEPTH];
  logic              ovfl_r;
  logic              unfl_r;

  logic [ADDR_W-1:0] pc_inc_s;
  logic [ADDR_W-1:0] pc_nxt_s;
  logic [ADDR_W-1:0] top_s;
  logic [PTR_W-1:0]  sp_nxt_s;
  logic [PTR_W-1:0]  sp_m1_s;
  logic              push_s;
  logic              ovfl_nxt_s;
  logic              unfl_nxt_s;
  logic              full_s;
  logic              empty_s;
  logic              unused_s;

  assign pc_inc_s = pc_r + ADDR_W'(1);
  assign sp_m1_s  = sp_r - PTR_W'(1);
  assign full_s   = (sp_r == PTR_W'(DEPTH));
  assign empty_s  = (sp_r == PTR_W'(0));
  assign top_s    = empty_s ? {ADDR_W{1'b0}} : stack_r[sp_m1_s[PTR_W-2:0]];
  assign unused_s = ^{bus.Crnt_Instrn[31:29], bus.Crnt_Instrn[27:ADDR_W], sp_m1_s[PTR_W-1]};

  assign bus.PC          = pc_r;
  assign bus.Stack_Top   = top_s;
  assign bus.Stack_Depth = sp_r;
  assign bus.Stack_Full  = full_s;
  assign bus.Stack_Empty = empty_s;
  assign bus.Stack_Ovfl  = ovfl_r;
  assign bus.Stack_Unfl  = unfl_r;

  // Next-state selection for PC, stack pointer and sticky flags.
  always_comb begin
    pc_nxt_s   = pc_r;
    sp_nxt_s   = sp_r;
    push_s     = 1'b0;
    ovfl_nxt_s = ovfl_r;
    unfl_nxt_s = unfl_r;
    if (bus.Ld_Rtn_Addr) begin
      if (!empty_s) begin
        pc_nxt_s = top_s;
        sp_nxt_s = sp_m1_s;
      end else begin
        // Return with nothing to pop falls through to the next instruction.
        pc_nxt_s   = pc_inc_s;
        unfl_nxt_s = 1'b1;
      end
    end else if (bus.Ld_Brnch_Addr) begin
      pc_nxt_s = bus.Crnt_Instrn[ADDR_W-1:0];
      if (bus.Crnt_Instrn[28]) begin
        if (!full_s) begin
          push_s   = 1'b1;
          sp_nxt_s = sp_r + PTR_W'(1);
        end else begin
          ovfl_nxt_s = 1'b1;
        end
      end else begin
        push_s = 1'b0;
      end
    end else if (bus.Incrmnt_PC) begin
      pc_nxt_s = pc_inc_s;
    end else begin
      pc_nxt_s = pc_r;
    end
  end

  // State registers and return-address storage.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pc_r   <= {ADDR_W{1'b0}};
      sp_r   <= {PTR_W{1'b0}};
      ovfl_r <= 1'b0;
      unfl_r <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        stack_r[i] <= {ADDR_W{1'b0}};
      end
    end else begin
      pc_r   <= pc_nxt_s;
      sp_r   <= sp_nxt_s;
      ovfl_r <= ovfl_nxt_s;
      unfl_r <= unfl_nxt_s;
      if (push_s) begin
        stack_r[sp_r[PTR_W-2:0]] <= pc_inc_s;
      end
    end
  end
endmodule

// File: doc/prgrm_cnt_stack.md
Name: prgrm_cnt_stack

Overview:
- Program counter and return-address stack, directly downstream of the program decode stage.
- Consumes Incrmnt_PC, Ld_Brnch_Addr and Ld_Rtn_Addr, which the decoder asserts only in WRITEBACK, plus the current instruction word.
- Updates the PC once per WRITEBACK. Pushes a return address on a taken Call and pops it on Return.
- Drives the PC to the instruction fetch path and reports stack status.

Parameters:
- ADDR_W, 8, PC and branch-target width; the target comes from Crnt_Instrn[ADDR_W-1:0].
- DEPTH, 8, number of return-address entries; power of two, at least 2.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Incrmnt_PC  input  1  PC <= PC+1 this cycle.
- Ld_Brnch_Addr  input  1  load branch target into PC this cycle.
- Ld_Rtn_Addr  input  1  load top of stack into PC and pop this cycle.
- Crnt_Instrn  input  32  current instruction from the instruction latch. Bit 28 = Call; [ADDR_W-1:0] = target.
- PC  output  ADDR_W  current program counter.
- Stack_Top  output  ADDR_W  entry at the top of the stack; 0 when empty.
- Stack_Depth  output  $clog2(DEPTH)+1  number of valid entries.
- Stack_Full  output  1  Stack_Depth == DEPTH.
- Stack_Empty  output  1  Stack_Depth == 0.
- Stack_Ovfl  output  1  sticky: a push was attempted while full.
- Stack_Unfl  output  1  sticky: a pop was attempted while empty.

Behaviour:
- Reset is asynchronous. On assertion, immediately: PC=0, stack pointer=0, all entries=0, Stack_Ovfl=0, Stack_Unfl=0. This gives Stack_Empty=1, Stack_Full=0, Stack_Top=0, Stack_Depth=0. Reset mid-operation discards any pending update.
- Update priority each rising edge: Ld_Rtn_Addr > Ld_Brnch_Addr > Incrmnt_PC > hold. Only the highest-priority asserted request acts.
- Return (Ld_Rtn_Addr=1):
  - Not empty: PC <= Stack_Top; pointer decrements.
  - Empty: PC <= PC+1; pointer unchanged; Stack_Ovfl unchanged; Stack_Unfl <= 1.
- Branch (Ld_Brnch_Addr=1, Ld_Rtn_Addr=0): PC <= Crnt_Instrn[ADDR_W-1:0].
  - If Crnt_Instrn[28]=1 (Call), push PC+1 (the current PC plus one, modulo 2^ADDR_W).
    - Not full: write the entry at the pointer; pointer increments.
    - Full: the branch is still taken, the return address is dropped, the pointer is unchanged, and Stack_Ovfl <= 1.
  - If Crnt_Instrn[28]=0 (Jmp), no stack change.
- Increment: PC <= PC+1, wrapping from 2^ADDR_W-1 to 0 with no flag.
- No request asserted: PC and stack hold.
- Latency: one clock. A new PC is visible the cycle after the request edge. Stack_Top, Stack_Depth, Stack_Full and Stack_Empty are combinational from registered state and update in the same cycle as PC.
- Stack_Ovfl and Stack_Unfl stay set until Reset.
- At most one push or pop per cycle, so simultaneous push and pop cannot occur by construction.
- Stack storage is a register array with no read-during-write hazard: Stack_Top reflects the post-edge state.

Test Plan:
- Reset then 3 cycles of Incrmnt_PC -> PC=3, Stack_Empty=1, Stack_Depth=0. Assert Reset asynchronously mid-cycle -> PC=0 before the next edge.
- At PC=0x10, Ld_Brnch_Addr=1, Crnt_Instrn=0x1000_0040 (Call to 0x40) -> PC=0x40, Stack_Top=0x11, Depth=1. Then Ld_Rtn_Addr -> PC=0x11, Stack_Empty=1.
- 9 consecutive Calls, each from a distinct PC -> Depth=8, Stack_Full=1 after the 8th. The 9th branch is taken but not pushed and Stack_Ovfl=1. Then 8 Returns pop the addresses in LIFO order; Stack_Ovfl stays 1.
- Ld_Rtn_Addr with the stack empty at PC=0x20 -> PC=0x21, Stack_Unfl=1, Depth=0.
- Ld_Brnch_Addr with Crnt_Instrn=0x2000_0055 (Jmp, bit 28=0) at PC=0x05 -> PC=0x55, Depth unchanged. Then Ld_Rtn_Addr and Ld_Brnch_Addr together with a non-empty stack (top=0x11) -> PC=0x11, no push.
- PC=0xFF with Incrmnt_PC -> PC=0x00. A Call from PC=0xFF to 0x30 pushes 0x00.
